// File: rtl/bit_serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// bit_serial_subtractor_if
// Groups the request and result signals of the bit-serial subtractor.
//   start : request to begin one subtraction (sampled on clk)
//   a, b  : N-bit unsigned minuend and subtrahend
//   bi    : borrow-in
//   busy  : operation in progress
//   done  : one-cycle pulse marking a valid result
//   d, bo : N-bit difference and borrow-out
// master : the requester (drives start/a/b/bi)
// slave  : the subtractor (drives busy/done/d/bo)
// -----------------------------------------------------------------------------
interface bit_serial_subtractor_if #(
    parameter int N = 10
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bo;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
    );
endinterface

// File: rtl/bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bit_serial_subtractor
// Computes d = (a - b - bi) mod 2^N and bo = (a < b + bi) one bit per clock,
// LSB first. A start seen in IDLE captures the operands; N RUN cycles follow,
// then a single DONE cycle in which done pulses.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bit_serial_subtractor_if.slave (start/a/b/bi in, busy/done/d/bo out)
// -----------------------------------------------------------------------------
module bit_serial_subtractor #(
    parameter int N = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bit_serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Single-bit full-subtractor difference.
    function automatic logic diff_bit(input logic x, input logic y, input logic br);
        return x ^ y ^ br;
    endfunction

    // Single-bit full-subtractor borrow.
    function automatic logic borrow_bit(input logic x, input logic y, input logic br);
        return (~x & (y | br)) | (y & br & x);
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic            capture_s;
    logic            step_s;
    logic            last_s;

    logic [N-1:0]    a_sr_r;
    logic [N-1:0]    b_sr_r;
    logic            br_r;
    logic [CW-1:0]   cnt_r;
    logic [N-1:0]    res_r;
    logic            bo_r;
    logic            busy_r;
    logic            done_r;

    logic            diff_s;
    logic            borrow_s;
    logic [N-1:0]    res_shift_s;

    assign diff_s   = diff_bit(a_sr_r[0], b_sr_r[0], br_r);
    assign borrow_s = borrow_bit(a_sr_r[0], b_sr_r[0], br_r);

    // Each new diff bit enters at the MSB so bit 0 lands at the LSB after N steps.
    generate
        if (N == 1) begin : g_res_one
            assign res_shift_s = diff_s;
        end else begin : g_res_many
            assign res_shift_s = {diff_s, res_r[N-1:1]};
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        step_s    = 1'b0;
        last_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s   = RUN;
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CW'(N - 1)) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand capture, serial subtraction and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r <= {N{1'b0}};
            b_sr_r <= {N{1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            res_r  <= {N{1'b0}};
            bo_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (capture_s) begin
                a_sr_r <= bus.a;
                b_sr_r <= bus.b;
                br_r   <= bus.bi;
                cnt_r  <= {CW{1'b0}};
            end else if (step_s) begin
                a_sr_r <= a_sr_r >> 1'b1;
                b_sr_r <= b_sr_r >> 1'b1;
                br_r   <= borrow_s;
                cnt_r  <= cnt_r + CW'(1);
                res_r  <= res_shift_s;
                // bo only moves on the final bit so it holds through IDLE.
                if (last_s) begin
                    bo_r <= borrow_s;
                end else begin
                    bo_r <= bo_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
            // Status outputs mirror the state being entered, so they are registered.
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = res_r;
    assign bus.bo   = bo_r;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_subtractor
// Directed bench for bit_serial_subtractor with N=10, plus an N=1 instance.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bit_serial_subtractor;
    localparam int N = 10;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    bit_serial_subtractor_if #(.N(N)) bus  ();
    bit_serial_subtractor_if #(.N(1)) bus1 ();

    bit_serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bit_serial_subtractor #(.N(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = 10'd0; bus.b = 10'd0; bus.bi = 1'b0;
        bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.bi = 1'b0;
        #2;
        vectors++;
        if ({bus.busy, bus.done, bus.bo} !== 3'b000 || bus.d !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_async: busy=%b done=%b d=%0d bo=%b, required all 0",
                     bus.busy, bus.done, bus.d, bus.bo);
        end
        bus.start = 1'b1;
        tick(); tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
        bus.start = 1'b0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    // One full operation with latency, result, pulse and hold checks.
    task automatic do_sub(input logic [N-1:0] av, input logic [N-1:0] bv, input logic biv,
                          input logic [N-1:0] exp_d, input logic exp_bo);
        int lat;
        bus.a = av; bus.b = bv; bus.bi = biv; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = ~av; bus.b = ~bv; bus.bi = ~biv;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL capture %0d-%0d-%0d: busy=%b done=%b, required 1 0",
                     av, bv, biv, bus.busy, bus.done);
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== N) begin
            miscompares++;
            $display("FAIL latency %0d-%0d-%0d: got %0d edges, required %0d", av, bv, biv, lat, N);
        end
        vectors++;
        if (bus.d !== exp_d || bus.bo !== exp_bo || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL result %0d-%0d-%0d: d=%0d bo=%b busy=%b, required d=%0d bo=%b busy=1",
                     av, bv, biv, bus.d, bus.bo, bus.busy, exp_d, exp_bo);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_end %0d-%0d-%0d: done=%b busy=%b, required 0 0",
                     av, bv, biv, bus.done, bus.busy);
        end
        tick();
        vectors++;
        if (bus.d !== exp_d || bus.bo !== exp_bo) begin
            miscompares++;
            $display("FAIL hold %0d-%0d-%0d: d=%0d bo=%b, required d=%0d bo=%b",
                     av, bv, biv, bus.d, bus.bo, exp_d, exp_bo);
        end
    endtask

    task automatic test_basic();
        do_sub(10'd5,    10'd3,    1'b0, 10'd2,    1'b0);
        do_sub(10'd3,    10'd5,    1'b0, 10'd1022, 1'b1);
        do_sub(10'd0,    10'd0,    1'b1, 10'd1023, 1'b1);
        do_sub(10'd1023, 10'd1023, 1'b0, 10'd0,    1'b0);
        do_sub(10'd512,  10'd0,    1'b1, 10'd511,  1'b0);
        do_sub(10'd0,    10'd1023, 1'b1, 10'd0,    1'b1);
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [N-1:0] got_d;
        logic got_bo;
        bus.a = 10'd5; bus.b = 10'd3; bus.bi = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.a = 10'd100; bus.b = 10'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ndone = 0; got_d = 10'd0; got_bo = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                got_d = bus.d;
                got_bo = bus.bo;
            end
        end
        vectors++;
        if (ndone !== 1 || got_d !== 10'd2 || got_bo !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start: dones=%0d d=%0d bo=%b, required 1 pulse d=2 bo=0",
                     ndone, got_d, got_bo);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        bus.a = 10'd5; bus.b = 10'd3; bus.bi = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.bo} !== 3'b000 || bus.d !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b d=%0d bo=%b, required all 0",
                     bus.busy, bus.done, bus.d, bus.bo);
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: dones=%0d, required 0", ndone);
        end
        #3 rst_n = 1'b1;
        tick();
        do_sub(10'd7, 10'd2, 1'b0, 10'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pa, pb, ca, cb;
        logic pbi, cbi, prev_busy;
        logic [N-1:0] exp_d;
        logic exp_bo;
        int diff, ndone, last_done;
        ca = 10'd0; cb = 10'd0; cbi = 1'b0;
        ndone = 0; last_done = -1;
        prev_busy = bus.busy;
        for (int i = 0; i < 56; i++) begin
            pa  = 10'($urandom_range(0, 1023));
            pb  = 10'($urandom_range(0, 1023));
            pbi = 1'($urandom_range(0, 1));
            bus.a = pa; bus.b = pb; bus.bi = pbi;
            bus.start = (i < 40) ? 1'b1 : 1'b0;
            tick();
            if (bus.busy === 1'b1 && prev_busy === 1'b0) begin
                ca = pa; cb = pb; cbi = pbi;
            end
            prev_busy = bus.busy;
            if (bus.done === 1'b1) begin
                diff   = int'(ca) - int'(cb) - int'(cbi);
                exp_d  = 10'((diff + 2048) % 1024);
                exp_bo = (diff < 0) ? 1'b1 : 1'b0;
                vectors++;
                if (bus.d !== exp_d || bus.bo !== exp_bo) begin
                    miscompares++;
                    $display("FAIL b2b_result %0d-%0d-%0d: d=%0d bo=%b, required d=%0d bo=%b",
                             ca, cb, cbi, bus.d, bus.bo, exp_d, exp_bo);
                end
                if (last_done >= 0) begin
                    vectors++;
                    if (i - last_done !== 12) begin
                        miscompares++;
                        $display("FAIL b2b_period: got %0d cycles, required 12", i - last_done);
                    end
                end
                last_done = i;
                ndone++;
            end
        end
        bus.start = 1'b0;
        vectors++;
        if (ndone !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d dones, required 4", ndone);
        end
    endtask

    task automatic test_n1();
        bus1.a = 1'b0; bus1.b = 1'b1; bus1.bi = 1'b0; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        vectors++;
        if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
            miscompares++;
            $display("FAIL n1_capture: busy=%b done=%b, required 1 0", bus1.busy, bus1.done);
        end
        tick();
        vectors++;
        if (bus1.done !== 1'b1 || bus1.d !== 1'b1 || bus1.bo !== 1'b1) begin
            miscompares++;
            $display("FAIL n1_result_0-1: done=%b d=%b bo=%b, required 1 1 1",
                     bus1.done, bus1.d, bus1.bo);
        end
        tick();
        vectors++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            miscompares++;
            $display("FAIL n1_idle: busy=%b done=%b, required 0 0", bus1.busy, bus1.done);
        end
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.bi = 1'b1; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        vectors++;
        if (bus1.done !== 1'b1 || bus1.d !== 1'b0 || bus1.bo !== 1'b0) begin
            miscompares++;
            $display("FAIL n1_result_1-0-1: done=%b d=%b bo=%b, required 1 0 0",
                     bus1.done, bus1.d, bus1.bo);
        end
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_n1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 10, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request to begin one subtraction; sampled on clk.
REQ-005 The block SHALL have port a  input  N  minuend, unsigned.
REQ-006 The block SHALL have port b  input  N  subtrahend, unsigned.
REQ-007 The block SHALL have port bi  input  1  borrow-in.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port d  output  N  difference.
REQ-011 The block SHALL have port bo  output  1  borrow-out.

Function
REQ-012 The block SHALL use a three-state FSM with states IDLE, RUN and DONE.
REQ-013 IDLE -> RUN SHALL occur on an edge where start=1; on that edge a, b and bi SHALL be captured into internal registers (operand shift registers and borrow register) and the bit counter SHALL be cleared.
REQ-014 In RUN, each edge SHALL process one bit, LSB first: diff = a_bit XOR b_bit XOR borrow; borrow_next = (~a_bit & (b_bit | borrow)) | (b_bit & borrow & a_bit).
REQ-015 In RUN, each diff bit SHALL be shifted into the result register from the MSB side, so that after N bits the register holds bit 0 at LSB.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit N-1, i.e. the Nth edge after capture; the counter SHALL be ceil(log2(N+1)) bits wide.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle per accepted start.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 Latency: with start captured at edge k, done=1 SHALL be observed between edges k+N and k+N+1.
REQ-021 In DONE and thereafter, d SHALL equal (a - b - bi) mod 2^N and bo SHALL equal 1 iff a < b + bi, using the operand values captured at the start edge.
REQ-022 d and bo SHALL hold their values through IDLE until the next accepted start; their value during RUN is undefined and SHALL NOT be relied on.
REQ-023 start SHALL be ignored in RUN and DONE; changes to a, b or bi after capture SHALL NOT affect the result.
REQ-024 start held high continuously SHALL produce back-to-back operations with one IDLE cycle between done and the next capture.
REQ-025 N=1 SHALL be supported: RUN lasts one cycle.

Reset
REQ-026 rst_n=0 SHALL immediately, regardless of clk, force: state IDLE, busy=0, done=0, d=0, bo=0, counter=0, and internal operand and borrow registers=0.
REQ-027 Assertion of rst_n in RUN or DONE SHALL abort the operation with no done pulse; the first start edge after rst_n returns high SHALL be accepted normally.

Verification
REQ-028 N=10, a=5, b=3, bi=0, start at edge k -> done at k+10, d=2, bo=0; busy high k..k+11 exclusive.
REQ-029 a=3, b=5, bi=0 -> d=1022, bo=1; a=0, b=0, bi=1 -> d=1023, bo=1; a=1023, b=1023, bi=0 -> d=0, bo=0.
REQ-030 start pulsed again at k+3 with a=100, b=1 -> ignored; result still that of the first operation, one done pulse only.
REQ-031 rst_n low at k+4 mid-RUN -> outputs zero asynchronously, no done; a new start after release with a=7, b=2 -> d=5, bo=0, done 10 cycles later.
REQ-032 start held high for 40 cycles with random a, b, bi -> done every 12 cycles, each result matches the reference model from REQ-021.
